// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between requesters, the arbiter and the UART TX.
// Ports: req_valid_i/req_data_i/req_ready_o per requester; tx_valid_o/tx_data_o/tx_ready_i to the UART.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ*8-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic                 tx_valid_o;
    logic [7:0]           tx_data_o;
    logic                 tx_ready_i;

    modport slave (
        input  req_valid_i, req_data_i, tx_ready_i,
        output req_ready_o, tx_valid_o, tx_data_o
    );

    modport master (
        output req_valid_i, req_data_i, tx_ready_i,
        input  req_ready_o, tx_valid_o, tx_data_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Line-granular round-robin arbiter sharing one UART TX among NUM_REQ byte streams.
// Ports: clk_i, rst_i (sync, active-high), bus (slave), owner_o, busy_o, timeout_o.
module uart_tx_arbiter #(
    parameter int          NUM_REQ  = 4,
    parameter int          TIMEOUT  = 1024,
    parameter logic [7:0]  EOL_CHAR = 8'h0A
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    uart_tx_arbiter_if.slave           bus,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       busy_o,
    output logic                       timeout_o
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t        r_state;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] r_last;
    logic [CW-1:0] r_cnt;
    logic          r_tx_valid;
    logic [7:0]    r_tx_data;
    logic          r_timeout;

    logic          w_accept;
    logic          w_xfer;
    logic [7:0]    w_byte;
    logic          w_eol;
    logic [OW-1:0] w_grant;

    // Owner may push whenever the output register is empty or draining.
    assign w_accept = (r_state == S_LOCKED) && (!r_tx_valid || bus.tx_ready_i);
    assign w_xfer   = w_accept && bus.req_valid_i[r_owner];
    assign w_byte   = bus.req_data_i[{r_owner, 3'b000} +: 8];
    assign w_eol    = w_xfer && (w_byte == EOL_CHAR);

    always_comb begin
        bus.req_ready_o = '0;
        if (w_accept) begin
            bus.req_ready_o[r_owner] = 1'b1;
        end
    end

    // Scan downward so the lowest offset from last owner wins.
    always_comb begin
        w_grant = r_owner;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (bus.req_valid_i[OW'((int'(r_last) + i) % NUM_REQ)]) begin
                w_grant = OW'((int'(r_last) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_last     <= OW'(NUM_REQ - 1);
            r_cnt      <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;

            // Output register drains in either state.
            if (w_xfer) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_byte;
            end else if (bus.tx_ready_i) begin
                r_tx_valid <= 1'b0;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (|bus.req_valid_i) begin
                        r_owner <= w_grant;
                        r_state <= S_LOCKED;
                        r_cnt   <= '0;
                    end
                end
                S_LOCKED: begin
                    // EOL takes priority over a coincident timeout.
                    if (w_xfer) begin
                        r_cnt <= '0;
                        if (w_eol) begin
                            r_state <= S_IDLE;
                            r_last  <= r_owner;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= S_IDLE;
                        r_last    <= r_owner;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.tx_valid_o = r_tx_valid;
    assign bus.tx_data_o  = r_tx_data;
    assign owner_o        = r_owner;
    assign busy_o         = (r_state == S_LOCKED);
    assign timeout_o      = r_timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_uart_tx_arbiter;
    localparam int         NR  = 4;
    localparam int         TMO = 8;
    localparam logic [7:0] EOL = 8'h0A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();
    logic [1:0] owner;
    logic       busy;
    logic       tmo;

    uart_tx_arbiter #(
        .NUM_REQ (NR),
        .TIMEOUT (TMO),
        .EOL_CHAR(EOL)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .bus      (bus),
        .owner_o  (owner),
        .busy_o   (busy),
        .timeout_o(tmo)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0]    src[NR][$];
    logic [NR-1:0] en;
    int            xlog[$];
    logic [7:0]    olog[$];
    int            ocyc[$];
    int            glog[$];
    logic [NR-1:0] rdy_seen;
    bit            prev_busy = 1'b0;

    // Reference model state
    bit         m_lock = 1'b0;
    int         m_own  = 0;
    int         m_last = NR - 1;
    int         m_idle = 0;
    bit         m_hold = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         m_tmo  = 1'b0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [NR-1:0] m_ready(bit tr);
        if (m_lock && (!m_hold || tr)) return NR'(1 << m_own);
        return '0;
    endfunction

    function automatic void m_step(logic [NR-1:0] v, logic [NR*8-1:0] d, bit tr, bit r);
        logic [NR-1:0] rd;
        bit            xf;
        logic [7:0]    b;
        if (r) begin
            m_lock = 0; m_own = 0; m_last = NR - 1; m_idle = 0;
            m_hold = 0; m_data = 8'h00; m_tmo = 0;
            return;
        end
        rd = m_ready(tr);
        xf = m_lock && rd[m_own] && v[m_own];
        b  = d[8*m_own +: 8];
        m_tmo = 0;
        if (m_hold && tr) m_hold = 0;
        if (xf) begin
            m_hold = 1;
            m_data = b;
        end
        if (!m_lock) begin
            if (v != '0) begin
                for (int i = 1; i <= NR; i++) begin
                    if (v[(m_last + i) % NR]) begin
                        m_own = (m_last + i) % NR;
                        break;
                    end
                end
                m_lock = 1;
                m_idle = 0;
            end
        end else if (xf) begin
            m_idle = 0;
            if (b == EOL) begin
                m_lock = 0;
                m_last = m_own;
            end
        end else begin
            m_idle++;
            if (m_idle == TMO) begin
                m_lock = 0;
                m_last = m_own;
                m_tmo  = 1;
            end
        end
    endfunction

    task automatic drive();
        logic [NR-1:0]   v;
        logic [NR*8-1:0] d;
        v = '0;
        d = '0;
        for (int k = 0; k < NR; k++) begin
            if (en[k] && src[k].size() > 0) begin
                v[k]       = 1'b1;
                d[8*k +: 8] = src[k][0];
            end
        end
        bus.req_valid_i = v;
        bus.req_data_i  = d;
    endtask

    task automatic tick();
        logic [NR-1:0]   v;
        logic [NR*8-1:0] d;
        bit              tr;
        bit              r;
        drive();
        @(negedge clk);
        v  = bus.req_valid_i;
        d  = bus.req_data_i;
        tr = bus.tx_ready_i;
        r  = rst;
        rdy_seen = bus.req_ready_o;
        if (!r) begin
            chk("req_ready", 32'(rdy_seen), 32'(m_ready(tr)));
            for (int k = 0; k < NR; k++) begin
                if (v[k] && rdy_seen[k]) begin
                    xlog.push_back(k);
                    void'(src[k].pop_front());
                end
            end
            if (bus.tx_valid_o && tr) begin
                olog.push_back(bus.tx_data_o);
                ocyc.push_back(cyc);
            end
        end
        @(posedge clk);
        cyc++;
        m_step(v, d, tr, r);
        #1;
        chk("tx_valid", 32'(bus.tx_valid_o), 32'(m_hold));
        if (m_hold) chk("tx_data", 32'(bus.tx_data_o), 32'(m_data));
        chk("owner", 32'(owner), 32'(m_own));
        chk("busy", 32'(busy), 32'(m_lock));
        chk("timeout", 32'(tmo), 32'(m_tmo));
        if (busy && !prev_busy) glog.push_back(int'(owner));
        prev_busy = busy;
    endtask

    task automatic clear_logs();
        xlog.delete();
        olog.delete();
        ocyc.delete();
        glog.delete();
    endtask

    initial begin
        logic [7:0] line[3];
        int         ex[12];
        int         n;
        line = '{8'h78, 8'h79, 8'h0A};
        ex   = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
        en   = '1;
        bus.tx_ready_i = 1'b1;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_tx_valid", 32'(bus.tx_valid_o), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data_o), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(tmo), 32'd0);
        rst = 1'b0;

        // Requester 2 sends "AB\n"
        clear_logs();
        src[2] = '{8'h41, 8'h42, 8'h0A};
        tick();
        chk("ab_owner", 32'(owner), 32'd2);
        chk("ab_busy", 32'(busy), 32'd1);
        repeat (3) tick();
        chk("ab_busy_eol", 32'(busy), 32'd0);
        tick();
        chk("ab_count", 32'(olog.size()), 32'd3);
        if (olog.size() == 3) begin
            chk("ab_b0", 32'(olog[0]), 32'h41);
            chk("ab_b1", 32'(olog[1]), 32'h42);
            chk("ab_b2", 32'(olog[2]), 32'h0A);
            chk("ab_consec", 32'(ocyc[2] - ocyc[0]), 32'd2);
        end

        // Reset with a byte held mid-line
        src[2] = '{8'h43, 8'h44, 8'h0A};
        bus.tx_ready_i = 1'b0;
        tick();
        tick();
        chk("mid_held", 32'(bus.tx_valid_o), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(bus.tx_valid_o), 32'd0);
        chk("mid_rst_owner", 32'(owner), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        for (int k = 0; k < NR; k++) src[k].delete();
        tick();
        rst = 1'b0;
        bus.tx_ready_i = 1'b1;

        // Round-robin with line locking
        clear_logs();
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 3; i++) begin
                src[0].push_back(line[i]);
                src[1].push_back(line[i]);
            end
        end
        for (int i = 0; i < 60; i++) begin
            tick();
            if (src[0].size() == 0 && src[1].size() == 0 && !busy) break;
        end
        tick();
        chk("rr_xfers", 32'(xlog.size()), 32'd12);
        if (xlog.size() == 12) begin
            for (int i = 0; i < 12; i++) chk("rr_src", 32'(xlog[i]), 32'(ex[i]));
        end
        chk("rr_bytes", 32'(olog.size()), 32'd12);
        if (olog.size() == 12) begin
            for (int i = 0; i < 12; i++) chk("rr_byte", 32'(olog[i]), 32'(line[i % 3]));
        end
        chk("rr_grants", 32'(glog.size()), 32'd4);
        if (glog.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("rr_grant", 32'(glog[i]), 32'(i % 2));
        end

        // Backpressure
        src[2] = '{8'h55, 8'h66, 8'h0A};
        bus.tx_ready_i = 1'b0;
        tick();
        chk("bp_owner", 32'(owner), 32'd2);
        tick();
        chk("bp_load", 32'(bus.tx_data_o), 32'h55);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(bus.tx_valid_o), 32'd1);
            chk("bp_data", 32'(bus.tx_data_o), 32'h55);
            chk("bp_ready", 32'(rdy_seen[2]), 32'd0);
        end
        bus.tx_ready_i = 1'b1;
        tick();
        chk("bp_next", 32'(bus.tx_data_o), 32'h66);
        repeat (3) tick();

        // Timeout release with requester 1 waiting
        src[3] = '{8'h5A};
        src[1] = '{8'h71, 8'h0A};
        tick();
        chk("to_owner3", 32'(owner), 32'd3);
        tick();
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n++;
            if (tmo) break;
        end
        chk("to_cycles", 32'(n), 32'd8);
        tick();
        chk("to_pulse_once", 32'(tmo), 32'd0);
        chk("to_owner1", 32'(owner), 32'd1);
        repeat (4) tick();

        // EOL transfer on the cycle the counter hits TIMEOUT-1
        src[0] = '{EOL};
        tick();
        chk("eot_owner", 32'(owner), 32'd0);
        en[0] = 1'b0;
        repeat (TMO - 1) tick();
        chk("eot_still_busy", 32'(busy), 32'd1);
        en[0] = 1'b1;
        tick();
        chk("eot_timeout", 32'(tmo), 32'd0);
        chk("eot_released", 32'(busy), 32'd0);
        tick();
        chk("eot_timeout2", 32'(tmo), 32'd0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            bus.tx_ready_i = ($urandom % 4) != 0;
            rst = ($urandom % 150) == 0;
            for (int k = 0; k < NR; k++) begin
                en[k] = ($urandom % 4) != 0;
                if (src[k].size() < 4 && ($urandom % 3) == 0) begin
                    if (($urandom % 5) == 0) src[k].push_back(EOL);
                    else src[k].push_back(8'($urandom));
                end
            end
            tick();
        end
        rst = 1'b0;
        en = '1;
        bus.tx_ready_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (src[0].size() == 0 && src[1].size() == 0 &&
                src[2].size() == 0 && src[3].size() == 0 &&
                !busy && !bus.tx_valid_o) break;
        end
        chk("drain_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
